// File: rtl/wdt_ctrl.sv
// rtl/wdt_ctrl.sv - R80515 watchdog timer with prescaler, two-step refresh and sticky status
//
// Purpose: software-started 15-bit watchdog counter advanced by a /12 or /192
// prescaler. Refresh needs a WDCON bit0 write (arm) immediately followed by a
// WDCON bit1 write (confirm) as the next SFR write. On overflow a one-cycle
// wdts pulse is produced and a sticky status flag is set that survives rst.
//
// Ports:
//   clk         clock
//   rst         internal reset, synchronous active-high (keeps wdt_status)
//   por         power-on reset, synchronous active-high (clears everything)
//   sfraddr     SFR address (7 bits)
//   sfrdatai    SFR write data
//   sfrwe       SFR write strobe
//   sfrdatao    readback of WDTREL / WDCON, 8'h00 otherwise
//   wdts        watchdog timeout pulse, one cycle
//   wdt_status  sticky watchdog-timeout flag
//
// Configuration macro: WDT_SFR_READBACK_EN builds the readback mux; without it
// sfrdatao is tied to 8'h00.

module wdt_ctrl #(
    parameter logic [6:0] WDTREL_ADDR = 7'h06,
    parameter logic [6:0] WDCON_ADDR  = 7'h2F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       por,
    input  logic [6:0] sfraddr,
    input  logic [7:0] sfrdatai,
    input  logic       sfrwe,
    output logic [7:0] sfrdatao,
    output logic       wdts,
    output logic       wdt_status
);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUN,
        ST_ARMED
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [14:0] r_cnt;
    logic [7:0]  r_presc;
    logic [7:0]  r_wdtrel;
    logic        r_wdts;
    logic        r_status;

    logic        w_wdcon_we;
    logic        w_wdtrel_we;
    logic        w_running;
    logic [7:0]  w_presc_max;
    logic        w_tick;
    logic        w_start;
    logic        w_refresh;
    logic        w_timeout_fire;
    logic [14:0] w_reload;

    assign w_wdcon_we  = sfrwe && (sfraddr == WDCON_ADDR);
    assign w_wdtrel_we = sfrwe && (sfraddr == WDTREL_ADDR);
    assign w_running   = (r_state != ST_STOPPED);
    assign w_presc_max = r_wdtrel[7] ? 8'd191 : 8'd11;
    // >= rather than == so a divisor change mid-period cannot strand the
    // prescaler above the new terminal count.
    assign w_tick      = w_running && (r_presc >= w_presc_max);
    assign w_start     = (r_state == ST_STOPPED) && w_wdcon_we && sfrdatai[1];
    // A write carrying both bit0 and bit1 only re-arms; it never confirms.
    assign w_refresh   = (r_state == ST_ARMED) && w_wdcon_we && sfrdatai[1] && !sfrdatai[0];
    // A confirm landing on the overflow tick takes priority over the timeout.
    assign w_timeout_fire = w_tick && (r_cnt == 15'h7FFF) && !w_refresh;
    assign w_reload    = {r_wdtrel[6:0], 8'h00};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_STOPPED: begin
                if (w_start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_timeout_fire) begin
                    w_next = ST_RUN;
                end else if (w_wdcon_we && sfrdatai[0]) begin
                    w_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // The first SFR write after arming decides: re-arm, confirm or abandon.
                if (w_timeout_fire) begin
                    w_next = ST_RUN;
                end else if (sfrwe) begin
                    if (w_wdcon_we && sfrdatai[0]) begin
                        w_next = ST_ARMED;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
            end
            default: w_next = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || por) begin
            r_state  <= ST_STOPPED;
            r_cnt    <= 15'h0000;
            r_presc  <= 8'h00;
            r_wdtrel <= 8'h00;
            r_wdts   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wdts  <= w_timeout_fire;
            if (w_wdtrel_we) begin
                r_wdtrel <= sfrdatai;
            end
            if (w_start || w_refresh) begin
                r_cnt   <= w_reload;
                r_presc <= 8'h00;
            end else if (w_running) begin
                if (w_tick) begin
                    r_presc <= 8'h00;
                    r_cnt   <= (r_cnt == 15'h7FFF) ? w_reload : r_cnt + 15'd1;
                end else begin
                    r_presc <= r_presc + 8'd1;
                end
            end
        end
    end

    // Sticky flag: only por clears it unconditionally; a timeout coinciding
    // with rst still records itself, and a set beats a software clear.
    always_ff @(posedge clk) begin
        if (por) begin
            r_status <= 1'b0;
        end else if (w_timeout_fire) begin
            r_status <= 1'b1;
        end else if (!rst && w_wdcon_we && !sfrdatai[7]) begin
            r_status <= 1'b0;
        end
    end

    assign wdts       = r_wdts;
    assign wdt_status = r_status;

`ifdef WDT_SFR_READBACK_EN
    always_comb begin
        sfrdatao = 8'h00;
        if (sfraddr == WDTREL_ADDR) begin
            sfrdatao = r_wdtrel;
        end else if (sfraddr == WDCON_ADDR) begin
            sfrdatao = {r_status, 4'b0000, w_running, 2'b00};
        end
    end
`else
    assign sfrdatao = 8'h00;
`endif

endmodule

// File: tb/tb_wdt_ctrl.sv
// tb/tb_wdt_ctrl.sv - self-checking bench for wdt_ctrl

module tb_wdt_ctrl;

    logic       clk;
    logic       rst;
    logic       por;
    logic [6:0] sfraddr;
    logic [7:0] sfrdatai;
    logic       sfrwe;
    logic [7:0] sfrdatao;
    logic       wdts;
    logic       wdt_status;

    int checks;
    int failures;

    localparam logic [6:0] A_REL = 7'h06;
    localparam logic [6:0] A_CON = 7'h2F;
    localparam logic [6:0] A_OTH = 7'h10;

    wdt_ctrl dut (
        .clk(clk),
        .rst(rst),
        .por(por),
        .sfraddr(sfraddr),
        .sfrdatai(sfrdatai),
        .sfrwe(sfrwe),
        .sfrdatao(sfrdatao),
        .wdts(wdts),
        .wdt_status(wdt_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rb(input logic [7:0] x);
`ifdef WDT_SFR_READBACK_EN
        return x;
`else
        return 8'h00 & x;
`endif
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic [6:0] a, input logic [7:0] d, input logic we,
                        input logic rs, input logic po);
        @(negedge clk);
        sfraddr  = a;
        sfrdatai = d;
        sfrwe    = we;
        rst      = rs;
        por      = po;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        step(a, d, 1'b1, 1'b0, 1'b0);
    endtask

    // Idle up to max cycles; n = cycle index at which wdts was seen, or -1.
    task automatic wait_wdts(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step(A_CON, 8'h00, 1'b0, 1'b0, 1'b0);
            if (wdts) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        logic       we;
        logic       rs;
        logic       po;
        logic       ew;
        logic       es;
        logic [7:0] erb;
    } vec_t;

    vec_t tbl[9];

    // Reference model: tracks the absolute cycle of the next timeout.
    bit         m_run;
    bit         m_arm;
    bit         m_status;
    logic [7:0] m_rel;
    int         m_dead;

    function automatic int period(input logic [7:0] r);
        return (32768 - 256 * int'(r[6:0])) * (r[7] ? 192 : 12);
    endfunction

    task automatic model(input int c, input logic [6:0] a, input logic [7:0] d,
                         input logic we, input logic rs, input logic po,
                         output bit ew);
        bit wc, wrl, to, rf;
        wc  = we && (a == A_CON);
        wrl = we && (a == A_REL);
        to  = m_run && (c == m_dead);
        rf  = m_arm && wc && d[1] && !d[0];
        ew  = 1'b0;
        if (rs || po) begin
            if (po) m_status = 1'b0;
            else if (to) m_status = 1'b1;
            m_run = 1'b0;
            m_arm = 1'b0;
            m_rel = 8'h00;
        end else begin
            ew = to && !rf;
            if (ew) m_status = 1'b1;
            else if (wc && !d[7]) m_status = 1'b0;
            if (!m_run) begin
                if (wc && d[1]) begin
                    m_run  = 1'b1;
                    m_dead = c + period(m_rel);
                end
            end else if (rf || ew) begin
                m_dead = c + period(m_rel);
                m_arm  = 1'b0;
            end else if (wc) begin
                m_arm = d[0];
            end else if (we) begin
                m_arm = 1'b0;
            end
            if (wrl) m_rel = d;
        end
    endtask

    initial begin
        int n;
        int c;
        bit ew;
        logic [6:0] ra;
        logic [7:0] rd;
        logic rwe, rrs;
        logic [7:0] erb;
        logic [7:0] con_list [6];

        checks   = 0;
        failures = 0;
        rst = 1'b0; por = 1'b1; sfrwe = 1'b0; sfraddr = A_OTH; sfrdatai = 8'h00;

        // Single-cycle register behaviour after por.
        tbl[0] = '{A_CON, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{A_REL, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F};
        tbl[2] = '{A_CON, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{A_CON, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04};
        tbl[4] = '{A_REL, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F};
        tbl[5] = '{A_CON, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04};
        tbl[6] = '{A_OTH, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7] = '{A_CON, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8] = '{A_REL, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].rs, tbl[i].po);
            check($sformatf("vec%0d_wdts", i), wdts, tbl[i].ew);
            check($sformatf("vec%0d_status", i), wdt_status, tbl[i].es);
            check($sformatf("vec%0d_rdata", i), sfrdatao, rb(tbl[i].erb));
        end

        // /12 prescaler, reload 0x7F: 256 ticks * 12 = 3072 cycles.
        step(A_CON, 8'h00, 1'b0, 1'b0, 1'b1);
        wr(A_REL, 8'h7F);
        wr(A_CON, 8'h02);
        wait_wdts(4000, n);
        check("first_timeout_latency", n, 3072);
        step(A_CON, 8'h00, 1'b0, 1'b0, 1'b0);
        check("wdts_one_cycle", wdts, 0);
        check("status_set", wdt_status, 1);
        check("wdcon_readback", sfrdatao, rb(8'h84));

        // /192 prescaler, reload 0x7F: 256 * 192 = 49152 cycles.
        step(A_CON, 8'h00, 1'b0, 1'b1, 1'b0);
        check("rst_keeps_status", wdt_status, 1);
        wr(A_REL, 8'hFF);
        wr(A_CON, 8'h82);
        wait_wdts(50000, n);
        check("div192_timeout_latency", n, 49152);

        // rst after timeout: stopped, status kept, no further pulses.
        step(A_CON, 8'h00, 1'b0, 1'b1, 1'b0);
        step(A_CON, 8'h00, 1'b0, 1'b1, 1'b0);
        check("rst2_status", wdt_status, 1);
        check("rst2_readback", sfrdatao, rb(8'h80));
        wait_wdts(1000, n);
        check("stopped_no_wdts", n, -1);
        step(A_CON, 8'h00, 1'b0, 1'b0, 1'b1);
        check("por_clears_status", wdt_status, 0);

        // Periodic refresh holds off the timeout.
        wr(A_REL, 8'h7F);
        wr(A_CON, 8'h02);
        for (int k = 0; k < 3; k++) begin
            wait_wdts(2000, n);
            check("refresh_window_quiet", n, -1);
            wr(A_CON, 8'h01);
            wr(A_CON, 8'h02);
        end
        wait_wdts(4000, n);
        check("timeout_after_last_refresh", n, 3072);

        // Arm, intervening WDTREL write, then confirm: refresh abandoned.
        wait_wdts(99, n);
        check("pre_arm_quiet", n, -1);
        wr(A_CON, 8'h01);
        wr(A_REL, 8'h7E);
        wr(A_CON, 8'h02);
        wait_wdts(3000, n);
        check("abandoned_refresh_schedule", n, 2970);

        // Confirm lands on the exact timeout cycle (reload 0x7E -> 6144).
        wr(A_REL, 8'h7F);
        wait_wdts(6141, n);
        check("pre_collision_quiet", n, -1);
        wr(A_CON, 8'h01);
        wr(A_CON, 8'h02);
        check("collision_no_wdts", wdts, 0);
        wait_wdts(4000, n);
        check("period_after_collision", n, 3072);

        // WDCON=0x03 only arms; schedule unchanged.
        wait_wdts(50, n);
        check("pre_03_quiet", n, -1);
        wr(A_CON, 8'h03);
        wait_wdts(3100, n);
        check("arm_only_schedule", n, 3021);

        // Randomized run against the deadline model.
        con_list[0] = 8'h01; con_list[1] = 8'h02; con_list[2] = 8'h03;
        con_list[3] = 8'h00; con_list[4] = 8'h80; con_list[5] = 8'h82;
        m_run = 0; m_arm = 0; m_status = 0; m_rel = 8'h00; m_dead = 0;
        c = 0;
        model(c, A_OTH, 8'h00, 1'b0, 1'b0, 1'b1, ew);
        step(A_OTH, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6000; i++) begin
            int r;
            c++;
            r   = $urandom_range(0, 99);
            rwe = 1'b0;
            rd  = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       ra = A_REL;
                1:       ra = A_CON;
                default: ra = A_OTH;
            endcase
            if (r < 3) begin
                ra = A_REL; rwe = 1'b1;
                rd = ($urandom_range(0, 2) == 0) ? 8'h7E : 8'h7F;
            end else if (r < 8) begin
                ra = A_CON; rwe = 1'b1;
                rd = con_list[$urandom_range(0, 5)];
            end else if (r == 8) begin
                ra = 7'($urandom_range(0, 127));
                if (ra == A_REL || ra == A_CON) ra = A_OTH;
                rwe = 1'b1;
            end
            rrs = ($urandom_range(0, 1999) == 0);
            model(c, ra, rd, rwe, rrs, 1'b0, ew);
            step(ra, rd, rwe, rrs, 1'b0);
            if (ra == A_REL) erb = m_rel;
            else if (ra == A_CON) erb = {m_status, 4'b0000, m_run, 2'b00};
            else erb = 8'h00;
            check($sformatf("rand%0d_wdts", i), wdts, ew);
            check($sformatf("rand%0d_status", i), wdt_status, m_status);
            check($sformatf("rand%0d_rdata", i), sfrdatao, rb(erb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
